// File: rtl/gpio_ctrl_apb_arb_pkg.sv
// ---------------------------------------------------------------------------
// gpio_ctrl_apb_arb_pkg
// Shared types and constants for the GPIO controller APB arbiter:
//   - arb_state_e  : transfer sequencer states (IDLE, SETUP, ACCESS, RESP)
//   - DEF_*_WIDTH  : default APB address/data widths of the GPIO register block
//   - xfer_resp_t  : response status of the transfer currently in flight
//   - rr_next()    : round-robin pointer advance (index after idx, modulo n)
// ---------------------------------------------------------------------------
package gpio_ctrl_apb_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 11;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    // Status of the transfer being completed in ACCESS.
    typedef struct packed {
        logic deliver;    // granted requester still holds psel & penable
        logic pslverr;    // error to return (slave error or watchdog abort)
        logic timed_out;  // watchdog expired before the slave was ready
    } xfer_resp_t;

    // Next round-robin start position after the requester just served.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1) % n;
    endfunction

endpackage

// File: rtl/gpio_ctrl_rr_arb.sv
// ---------------------------------------------------------------------------
// gpio_ctrl_rr_arb
// Combinational round-robin picker. Returns the first asserted request at or
// after the pointer, wrapping modulo NUM_REQ. The pointer register is owned
// by the parent so it only advances when a transfer really completes.
// Ports:
//   req_i   [NUM_REQ]        request vector
//   ptr_i   [clog2(NUM_REQ)] highest-priority position
//   valid_o                  at least one request is present
//   grant_o [clog2(NUM_REQ)] selected requester index
// ---------------------------------------------------------------------------
module gpio_ctrl_rr_arb #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic                       valid_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_o
);

    localparam int IW = $clog2(NUM_REQ);

    logic [2*NUM_REQ-1:0] req_dbl_s;
    logic [NUM_REQ-1:0]   req_rot_s;
    logic                 valid_s;
    logic [IW-1:0]        grant_s;

    // Rotate requests so bit 0 is the pointer position; the doubled copy
    // provides the wrap-around.
    assign req_dbl_s = {req_i, req_i} >> ptr_i;
    assign req_rot_s = req_dbl_s[NUM_REQ-1:0];

    // Scan from the far end back toward the pointer so the nearest request wins.
    always_comb begin
        valid_s = 1'b0;
        grant_s = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            valid_s = valid_s | req_rot_s[k];
            grant_s = req_rot_s[k] ? IW'((int'(ptr_i) + k) % NUM_REQ) : grant_s;
        end
    end

    assign valid_o = valid_s;
    assign grant_o = grant_s;

endmodule

// File: rtl/gpio_ctrl_apb_arb.sv
// ---------------------------------------------------------------------------
// gpio_ctrl_apb_arb
// Round-robin arbiter sharing the GPIO controller's APB slave port between
// NUM_REQ upstream requesters, with an ACCESS-phase watchdog.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   s_psel/s_penable/s_pwrite [N]      upstream APB control per requester
//   s_paddr/s_pstrb/s_pwdata (packed)  upstream request payload, lane i at i*W
//   s_prdata/s_pready/s_pslverr        registered upstream response (granted lane only)
//   m_psel/m_penable/m_pwrite/m_paddr/m_pstrb/m_pwdata  registered downstream request
//   m_prdata/m_pready/m_pslverr        downstream response
//   timeout_pulse                      one-cycle pulse when the watchdog aborts
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module gpio_ctrl_apb_arb
    import gpio_ctrl_apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               s_psel,
    input  logic [NUM_REQ-1:0]               s_penable,
    input  logic [NUM_REQ-1:0]               s_pwrite,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    s_paddr,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  s_pstrb,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    s_pwdata,
    output logic [NUM_REQ*DATA_WIDTH-1:0]    s_prdata,
    output logic [NUM_REQ-1:0]               s_pready,
    output logic [NUM_REQ-1:0]               s_pslverr,
    output logic                             m_psel,
    output logic                             m_penable,
    output logic                             m_pwrite,
    output logic [ADDR_WIDTH-1:0]            m_paddr,
    output logic [DATA_WIDTH/8-1:0]          m_pstrb,
    output logic [DATA_WIDTH-1:0]            m_pwdata,
    input  logic [DATA_WIDTH-1:0]            m_prdata,
    input  logic                             m_pready,
    input  logic                             m_pslverr,
    output logic                             timeout_pulse
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic          TO_EN    = (TIMEOUT_CYCLES != 0);

    arb_state_e                    state_q;
    logic [IW-1:0]                 ptr_q;
    logic [IW-1:0]                 grant_q;
    logic [CW-1:0]                 cnt_q;
    logic                          m_psel_q;
    logic                          m_penable_q;
    logic                          m_pwrite_q;
    logic [ADDR_WIDTH-1:0]         m_paddr_q;
    logic [SW-1:0]                 m_pstrb_q;
    logic [DATA_WIDTH-1:0]         m_pwdata_q;
    logic [NUM_REQ*DATA_WIDTH-1:0] s_prdata_q;
    logic [NUM_REQ-1:0]            s_pready_q;
    logic [NUM_REQ-1:0]            s_pslverr_q;
    logic                          timeout_q;

    logic                          pick_valid_s;
    logic [IW-1:0]                 pick_grant_s;
    logic                          sel_write_s;
    logic [ADDR_WIDTH-1:0]         sel_addr_s;
    logic [SW-1:0]                 sel_strb_s;
    logic [DATA_WIDTH-1:0]         sel_wdata_s;
    xfer_resp_t                    resp_s;
    logic [DATA_WIDTH-1:0]         resp_rdata_s;
    logic                          acc_done_s;
    logic [NUM_REQ-1:0]            pready_d;
    logic [NUM_REQ-1:0]            pslverr_d;
    logic [NUM_REQ*DATA_WIDTH-1:0] prdata_d;
    logic [IW-1:0]                 ptr_d;

    gpio_ctrl_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arb (
        .req_i   (s_psel),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid_s),
        .grant_o (pick_grant_s)
    );

    // Select the request payload of the requester the picker chose.
    always_comb begin
        sel_write_s = 1'b0;
        sel_addr_s  = '0;
        sel_strb_s  = '0;
        sel_wdata_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel_write_s = (pick_grant_s == IW'(k)) ? s_pwrite[k] : sel_write_s;
            sel_addr_s  = (pick_grant_s == IW'(k)) ? s_paddr[k*ADDR_WIDTH +: ADDR_WIDTH] : sel_addr_s;
            sel_strb_s  = (pick_grant_s == IW'(k)) ? s_pstrb[k*SW +: SW] : sel_strb_s;
            sel_wdata_s = (pick_grant_s == IW'(k)) ? s_pwdata[k*DATA_WIDTH +: DATA_WIDTH] : sel_wdata_s;
        end
    end

    // Build the response the granted lane receives when ACCESS completes.
    // A ready slave always beats a watchdog expiring in the same cycle.
    always_comb begin
        resp_s.timed_out = TO_EN & ~m_pready & (cnt_q == TO_LIMIT);
        resp_s.pslverr   = m_pready ? m_pslverr : 1'b1;
        resp_s.deliver   = s_psel[grant_q] & s_penable[grant_q];
        resp_rdata_s     = m_pready ? m_prdata : '0;
        acc_done_s       = m_pready | resp_s.timed_out;
        pready_d         = '0;
        pslverr_d        = '0;
        prdata_d         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pready_d[k]  = resp_s.deliver & (grant_q == IW'(k));
            pslverr_d[k] = pready_d[k] & resp_s.pslverr;
            prdata_d[k*DATA_WIDTH +: DATA_WIDTH] = pready_d[k] ? resp_rdata_s : '0;
        end
    end

    assign ptr_d = IW'(rr_next(32'(grant_q), NUM_REQ));

    // Transfer sequencer: a single registered FSM produces every output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            m_psel_q    <= 1'b0;
            m_penable_q <= 1'b0;
            m_pwrite_q  <= 1'b0;
            m_paddr_q   <= '0;
            m_pstrb_q   <= '0;
            m_pwdata_q  <= '0;
            s_prdata_q  <= '0;
            s_pready_q  <= '0;
            s_pslverr_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    s_pready_q  <= '0;
                    s_pslverr_q <= '0;
                    s_prdata_q  <= '0;
                    timeout_q   <= 1'b0;
                    m_penable_q <= 1'b0;
                    if (pick_valid_s) begin
                        grant_q    <= pick_grant_s;
                        m_pwrite_q <= sel_write_s;
                        m_paddr_q  <= sel_addr_s;
                        m_pstrb_q  <= sel_strb_s;
                        m_pwdata_q <= sel_wdata_s;
                        m_psel_q   <= 1'b1;
                        state_q    <= SETUP;
                    end else begin
                        m_psel_q   <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                SETUP: begin
                    m_penable_q <= 1'b1;
                    cnt_q       <= '0;
                    state_q     <= ACCESS;
                end
                ACCESS: begin
                    if (acc_done_s) begin
                        m_psel_q    <= 1'b0;
                        m_penable_q <= 1'b0;
                        s_pready_q  <= pready_d;
                        s_pslverr_q <= pslverr_d;
                        s_prdata_q  <= prdata_d;
                        timeout_q   <= resp_s.timed_out;
                        state_q     <= RESP;
                    end else begin
                        cnt_q       <= cnt_q + CNT_ONE;
                        state_q     <= ACCESS;
                    end
                end
                RESP: begin
                    s_pready_q  <= '0;
                    s_pslverr_q <= '0;
                    s_prdata_q  <= '0;
                    timeout_q   <= 1'b0;
                    ptr_q       <= ptr_d;
                    state_q     <= IDLE;
                end
                default: begin
                    m_psel_q    <= 1'b0;
                    m_penable_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign m_psel        = m_psel_q;
    assign m_penable     = m_penable_q;
    assign m_pwrite      = m_pwrite_q;
    assign m_paddr       = m_paddr_q;
    assign m_pstrb       = m_pstrb_q;
    assign m_pwdata      = m_pwdata_q;
    assign s_prdata      = s_prdata_q;
    assign s_pready      = s_pready_q;
    assign s_pslverr     = s_pslverr_q;
    assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_gpio_ctrl_apb_arb.sv
// ---------------------------------------------------------------------------
// tb_gpio_ctrl_apb_arb
// Directed plus randomized bench for gpio_ctrl_apb_arb (NUM_REQ=2,
// TIMEOUT_CYCLES=4). A transaction-level model predicts the grant order,
// the cycle in which each response appears and its contents.
// ---------------------------------------------------------------------------
module tb_gpio_ctrl_apb_arb;

    localparam int NR = 2;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     s_psel;
    logic [NR-1:0]     s_penable;
    logic [NR-1:0]     s_pwrite;
    logic [NR*AW-1:0]  s_paddr;
    logic [NR*SW-1:0]  s_pstrb;
    logic [NR*DW-1:0]  s_pwdata;
    logic [NR*DW-1:0]  s_prdata;
    logic [NR-1:0]     s_pready;
    logic [NR-1:0]     s_pslverr;
    logic              m_psel;
    logic              m_penable;
    logic              m_pwrite;
    logic [AW-1:0]     m_paddr;
    logic [SW-1:0]     m_pstrb;
    logic [DW-1:0]     m_pwdata;
    logic [DW-1:0]     m_prdata;
    logic              m_pready;
    logic              m_pslverr;
    logic              timeout_pulse;

    always #5 clk = ~clk;

    gpio_ctrl_apb_arb #(
        .NUM_REQ        (NR),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_psel        (s_psel),
        .s_penable     (s_penable),
        .s_pwrite      (s_pwrite),
        .s_paddr       (s_paddr),
        .s_pstrb       (s_pstrb),
        .s_pwdata      (s_pwdata),
        .s_prdata      (s_prdata),
        .s_pready      (s_pready),
        .s_pslverr     (s_pslverr),
        .m_psel        (m_psel),
        .m_penable     (m_penable),
        .m_pwrite      (m_pwrite),
        .m_paddr       (m_paddr),
        .m_pstrb       (m_pstrb),
        .m_pwdata      (m_pwdata),
        .m_prdata      (m_prdata),
        .m_pready      (m_pready),
        .m_pslverr     (m_pslverr),
        .timeout_pulse (timeout_pulse)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: per-requester transfer descriptors and pointer.
    logic [AW-1:0] t_addr  [NR];
    logic          t_wr    [NR];
    logic [SW-1:0] t_strb  [NR];
    logic [DW-1:0] t_wdata [NR];
    int            t_waits [NR];
    logic [DW-1:0] t_rdata [NR];
    logic          t_err   [NR];
    logic          t_aband [NR];
    int            ptr_m;
    logic [AW-1:0] last_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string pre);
        chk({pre, "_m_psel"},    64'(m_psel),        64'(0));
        chk({pre, "_m_penable"}, 64'(m_penable),     64'(0));
        chk({pre, "_m_pwrite"},  64'(m_pwrite),      64'(0));
        chk({pre, "_m_paddr"},   64'(m_paddr),       64'(0));
        chk({pre, "_m_pstrb"},   64'(m_pstrb),       64'(0));
        chk({pre, "_m_pwdata"},  64'(m_pwdata),      64'(0));
        chk({pre, "_s_pready"},  64'(s_pready),      64'(0));
        chk({pre, "_s_prdata"},  64'(s_prdata),      64'(0));
        chk({pre, "_s_pslverr"}, 64'(s_pslverr),     64'(0));
        chk({pre, "_timeout"},   64'(timeout_pulse), 64'(0));
    endtask

    // First pending requester at or after the pointer, wrapping around.
    function automatic int pick(input int mask, input int ptr);
        int res = -1;
        for (int k = 0; k < NR; k++) begin
            int i = (ptr + k) % NR;
            if (res < 0 && mask[i]) res = i;
        end
        return res;
    endfunction

    task automatic set_req(input int r, input logic wr, input logic [AW-1:0] addr,
                           input logic [SW-1:0] strb, input logic [DW-1:0] wdata,
                           input int waits, input logic [DW-1:0] rdata,
                           input logic err, input logic aband);
        t_wr[r] = wr; t_addr[r] = addr; t_strb[r] = strb; t_wdata[r] = wdata;
        t_waits[r] = waits; t_rdata[r] = rdata; t_err[r] = err; t_aband[r] = aband;
    endtask

    // Issue all requesters in mask in the current (IDLE) cycle and follow
    // every transfer to completion, checking outputs each cycle.
    // Phase p: 0 = IDLE, 1 = SETUP, 2.. = ACCESS, rp = response cycle.
    task automatic run_batch(input int mask);
        int pend, g, len, rp;
        logic tmo, eexp;
        logic [DW-1:0] dexp;
        logic [NR-1:0] rdy_exp;
        logic [NR*DW-1:0] rd_exp;
        pend = mask;
        for (int r = 0; r < NR; r++) begin
            if (mask[r]) begin
                s_psel[r] = 1'b1; s_penable[r] = 1'b0; s_pwrite[r] = t_wr[r];
                s_paddr[r*AW +: AW] = t_addr[r]; s_pstrb[r*SW +: SW] = t_strb[r];
                s_pwdata[r*DW +: DW] = t_wdata[r];
            end
        end
        while (pend != 0) begin
            g    = pick(pend, ptr_m);
            tmo  = (t_waits[g] > TO);
            len  = tmo ? TO + 1 : t_waits[g] + 1;
            rp   = 2 + len;
            dexp = tmo ? '0 : t_rdata[g];
            eexp = tmo ? 1'b1 : t_err[g];
            rdy_exp = '0;
            rd_exp  = '0;
            if (!t_aband[g]) begin
                rdy_exp[g] = 1'b1;
                rd_exp[g*DW +: DW] = dexp;
            end
            for (int p = 0; p <= rp; p++) begin
                chk("m_psel",    64'(m_psel),    64'(p >= 1 && p < rp));
                chk("m_penable", 64'(m_penable), 64'(p >= 2 && p < rp));
                if (p >= 1 && p < rp) chk("m_paddr", 64'(m_paddr), 64'(t_addr[g]));
                if (p == 1) begin
                    chk("m_pwrite", 64'(m_pwrite), 64'(t_wr[g]));
                    chk("m_pstrb",  64'(m_pstrb),  64'(t_strb[g]));
                    chk("m_pwdata", 64'(m_pwdata), 64'(t_wdata[g]));
                end
                chk("s_pready",  64'(s_pready),  (p == rp) ? 64'(rdy_exp) : 64'(0));
                chk("s_pslverr", 64'(s_pslverr), (p == rp && eexp) ? 64'(rdy_exp) : 64'(0));
                chk("s_prdata",  64'(s_prdata),  (p == rp) ? 64'(rd_exp) : 64'(0));
                chk("timeout_pulse", 64'(timeout_pulse), 64'(p == rp && tmo));
                if (p == 1) s_penable = s_penable | NR'(pend);
                if (p == 2 && t_aband[g]) begin s_psel[g] = 1'b0; s_penable[g] = 1'b0; end
                if (p == rp) begin s_psel[g] = 1'b0; s_penable[g] = 1'b0; end
                m_pready  = (p >= 2 && p < rp && (p - 2) == t_waits[g]);
                m_prdata  = m_pready ? t_rdata[g] : $urandom();
                m_pslverr = m_pready ? t_err[g] : 1'($urandom());
                @(negedge clk);
            end
            pend      = pend & ~(1 << g);
            ptr_m     = (g + 1) % NR;
            last_addr = t_addr[g];
        end
        chk("idle_m_psel",   64'(m_psel),   64'(0));
        chk("idle_s_pready", 64'(s_pready), 64'(0));
        chk("hold_m_paddr",  64'(m_paddr),  64'(last_addr));
    endtask

    initial begin
        rst_n = 1'b1; s_psel = '0; s_penable = '0; s_pwrite = '0; s_paddr = '0;
        s_pstrb = '0; s_pwdata = '0; m_prdata = '0; m_pready = 1'b0; m_pslverr = 1'b0;
        ptr_m = 0; last_addr = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Simultaneous requests after reset: 0 then 1, twice.
        set_req(0, 1'b1, 11'h010, 4'hF, 32'hA5A5_0001, 0, 32'h0, 1'b0, 1'b0);
        set_req(1, 1'b0, 11'h020, 4'h0, 32'h0, 1, 32'hCAFE_0001, 1'b0, 1'b0);
        run_batch(3);
        set_req(0, 1'b0, 11'h030, 4'h0, 32'h0, 2, 32'h0BAD_F00D, 1'b0, 1'b0);
        set_req(1, 1'b1, 11'h034, 4'h3, 32'h5555_AAAA, 0, 32'h0, 1'b0, 1'b0);
        run_batch(3);

        // Requester 1 read with 3 wait states.
        set_req(1, 1'b0, 11'h040, 4'h0, 32'h0, 3, 32'h1234_5678, 1'b0, 1'b0);
        run_batch(2);

        // Requester 0 zero-wait write.
        set_req(0, 1'b1, 11'h010, 4'hF, 32'hA5A5_0001, 0, 32'h0, 1'b0, 1'b0);
        run_batch(1);

        // Slave never ready: watchdog abort.
        set_req(0, 1'b0, 11'h7FF, 4'h0, 32'h0, 99, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_batch(1);

        // Slave error forwarded only to the granted requester.
        set_req(0, 1'b1, 11'h100, 4'h1, 32'h0000_00C3, 0, 32'h0, 1'b0, 1'b0);
        set_req(1, 1'b0, 11'h104, 4'h0, 32'h0, 1, 32'h8765_4321, 1'b1, 1'b0);
        run_batch(3);

        // Ready arrives in the same cycle the watchdog would fire.
        set_req(1, 1'b0, 11'h200, 4'h0, 32'h0, TO, 32'h0F0F_0F0F, 1'b0, 1'b0);
        run_batch(2);

        // Requester abandons during ACCESS.
        set_req(0, 1'b1, 11'h300, 4'hC, 32'h1111_2222, 2, 32'h0, 1'b0, 1'b1);
        run_batch(1);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            int mask;
            mask = $urandom_range(3, 1);
            for (int r = 0; r < NR; r++)
                set_req(r, 1'($urandom()), AW'($urandom()), SW'($urandom()), $urandom(),
                        $urandom_range(5, 0), $urandom(), 1'($urandom()), 1'b0);
            if (mask != 3 && $urandom_range(3, 0) == 0) begin
                t_aband[mask - 1] = 1'b1;
                t_waits[mask - 1] = $urandom_range(TO, 0);
            end
            run_batch(mask);
        end

        // Leave the pointer at 1, then reset during ACCESS.
        set_req(0, 1'b0, 11'h050, 4'h0, 32'h0, 0, 32'h2468_ACE0, 1'b0, 1'b0);
        run_batch(1);
        s_psel[1] = 1'b1; s_pwrite[1] = 1'b1; s_paddr[AW +: AW] = 11'h3C3;
        s_pstrb[SW +: SW] = 4'hA; s_pwdata[DW +: DW] = 32'hDEAD_BEEF;
        @(negedge clk);
        s_penable[1] = 1'b1;
        @(negedge clk);
        chk("pre_rst_m_penable", 64'(m_penable), 64'(1));
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        s_psel = '0; s_penable = '0;
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_m_psel",   64'(m_psel),   64'(0));
            chk("post_rst_s_pready", 64'(s_pready), 64'(0));
        end

        // Pointer must be back at 0 after reset.
        set_req(0, 1'b1, 11'h060, 4'h5, 32'h1357_9BDF, 1, 32'h0, 1'b0, 1'b0);
        set_req(1, 1'b0, 11'h064, 4'h0, 32'h0, 0, 32'hFEDC_BA98, 1'b0, 1'b0);
        run_batch(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
